// File: rtl/prbs23_chk_ctrl.sv
// prbs23_chk_ctrl: sequencing controller for a PRBS23 (x^23 + x^18 + 1)
// checker. It seeds and advances an external generator, compares received
// words against it, and runs a hunt/verify/lock FSM with error counters.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   chk_en, clr_cnt   checker enable, synchronous counter clear
//   rx_valid, rx_data received 23-bit word (bit 0 oldest)
//   gen_load/enable   generator controls, gen_seed seed value
//   gen_m             generator state (expected word)
//   state, locked     FSM state (0 HUNT, 1 VERIFY, 2 LOCKED)
//   err_pulse         one cycle per compared mismatching word
//   err_cnt, word_cnt saturating bit-error / word counters (LOCKED only)

module prbs23_chk_ctrl #(
    parameter int unsigned LOCK_CNT = 8,
    parameter int unsigned LOSS_CNT = 4,
    parameter int unsigned CW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          chk_en,
    input  logic          clr_cnt,
    input  logic          rx_valid,
    input  logic [22:0]   rx_data,
    output logic          gen_load,
    output logic          gen_enable,
    output logic [22:0]   gen_seed,
    input  logic [22:0]   gen_m,
    output logic [1:0]    state,
    output logic          locked,
    output logic          err_pulse,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] word_cnt
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]    LOCK_N = LOCK_CNT[7:0];
    localparam logic [7:0]    LOSS_N = LOSS_CNT[7:0];
    localparam logic [CW-1:0] CMAX   = '1;

    state_t      st;
    logic        s1_v;
    logic [22:0] s1_d;
    logic        s2_v;
    logic [22:0] s2_d;
    logic [7:0]  run_cnt;

    logic [22:0] diff;
    logic        mismatch;
    logic [4:0]  nerr;
    logic        cmp;
    logic [CW:0] err_sum;

    assign state      = st;
    assign gen_seed   = s1_d;
    // An all-zero seed would park the LFSR forever, so it never loads.
    assign gen_load   = s1_v && (st == HUNT) && (s1_d != '0);
    assign gen_enable = s1_v && (st != HUNT);

    assign diff     = s2_d ^ gen_m;
    assign mismatch = |diff;
    // Tokens still in flight when the FSM falls back to HUNT are dropped.
    assign cmp      = s2_v && (st != HUNT) && chk_en;

    always_comb begin
        nerr = '0;
        for (int i = 0; i < 23; i++) begin
            nerr = nerr + 5'(diff[i]);
        end
    end

    assign err_sum = {1'b0, err_cnt} + {{(CW-4){1'b0}}, nerr};

    // Two-stage word pipeline: S1 drives the generator, S2 compares.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1_d <= '0;
            s2_v <= 1'b0;
            s2_d <= '0;
        end else begin
            s1_v <= rx_valid && chk_en;
            if (rx_valid && chk_en) begin
                s1_d <= rx_data;
            end
            s2_v <= gen_enable && chk_en;
            if (gen_enable) begin
                s2_d <= s1_d;
            end
        end
    end

    // FSM with registered outputs; run_cnt is the match counter in
    // VERIFY and the loss counter in LOCKED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= HUNT;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            run_cnt   <= '0;
            err_cnt   <= '0;
            word_cnt  <= '0;
        end else begin
            err_pulse <= cmp && mismatch;

            if (!chk_en) begin
                st      <= HUNT;
                locked  <= 1'b0;
                run_cnt <= '0;
            end else begin
                unique case (st)
                    HUNT: begin
                        if (gen_load) begin
                            st      <= VERIFY;
                            run_cnt <= '0;
                        end
                    end
                    VERIFY: begin
                        if (cmp) begin
                            if (mismatch) begin
                                st      <= HUNT;
                                run_cnt <= '0;
                            end else if (run_cnt == LOCK_N - 8'd1) begin
                                st      <= LOCKED;
                                locked  <= 1'b1;
                                run_cnt <= '0;
                            end else begin
                                run_cnt <= run_cnt + 8'd1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (cmp) begin
                            if (!mismatch) begin
                                run_cnt <= '0;
                            end else if (run_cnt == LOSS_N - 8'd1) begin
                                st      <= HUNT;
                                locked  <= 1'b0;
                                run_cnt <= '0;
                            end else begin
                                run_cnt <= run_cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        st      <= HUNT;
                        locked  <= 1'b0;
                        run_cnt <= '0;
                    end
                endcase
            end

            // Clear has priority over a same-cycle increment.
            if (clr_cnt) begin
                err_cnt  <= '0;
                word_cnt <= '0;
            end else if (cmp && (st == LOCKED)) begin
                if (word_cnt != CMAX) begin
                    word_cnt <= word_cnt + {{(CW-1){1'b0}}, 1'b1};
                end
                if (err_sum[CW]) begin
                    err_cnt <= CMAX;
                end else begin
                    err_cnt <= err_sum[CW-1:0];
                end
            end
        end
    end

endmodule
